mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DepthLog2, default 2, log2 of the outstanding-read tracking FIFO depth.
REQ-002 SHALL have parameter StarveLimit, default 4, the number of consecutive data grants after which a waiting inst request wins.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports inst_valid_i/inst_ready_o, in/out, 1/1, the inst requester handshake.
REQ-006 SHALL have ports inst_addr_i/inst_wdata_i/inst_wmask_i, in, 32/32/4, the inst request payload.
REQ-007 SHALL have ports inst_rdata_o/inst_rvalid_o, out, 32/1, the inst read response.
REQ-008 SHALL have ports data_valid_i, data_ready_o, data_addr_i, data_wdata_i, data_wmask_i, data_rdata_o and data_rvalid_o, with directions and widths identical to the inst_* ports, forming the data requester.
REQ-009 SHALL have ports mem_valid_o/mem_ready_i, out/in, 1/1, the shared memory request handshake.
REQ-010 SHALL have ports mem_addr_o/mem_wdata_o/mem_wmask_o, out, 32/32/4, the shared memory request payload.
REQ-011 SHALL have ports mem_rdata_i/mem_rvalid_i, in, 32/1, the memory read response, which returns in request order.
REQ-012 SHALL have port err_o, output, 1, sticky flag raised by an unexpected response.

Function
REQ-013 SHALL treat a request as accepted in a cycle where mem_valid_o && mem_ready_i; a read is wmask==0, a write is wmask!=0.
REQ-014 SHALL select a winner combinationally among valid requesters: data wins over inst, except as REQ-019 requires.
REQ-015 SHALL drive mem_valid_o, mem_addr_o, mem_wdata_o and mem_wmask_o from the winner; when no requester is valid, mem_valid_o=0 and mem_wmask_o=0.
REQ-016 SHALL lock the grant while mem_valid_o && !mem_ready_i (stalled), so that neither the winner nor the payload changes until acceptance.
REQ-017 SHALL drive <winner>_ready_o = mem_ready_i && !track_full and the loser's ready_o = 0.
REQ-018 SHALL suppress mem_valid_o for a read while the tracking FIFO is full; writes are not suppressed.
REQ-019 SHALL count consecutive accepted data grants while inst_valid_i is asserted; once the count reaches StarveLimit, inst wins the next arbitration.
REQ-020 SHALL clear the starvation counter on any inst acceptance or whenever inst_valid_i=0.
REQ-021 SHALL push a 1-bit source tag (0=inst, 1=data) into a 2^DepthLog2-entry FIFO on each accepted read; writes produce no tag and no response.
REQ-022 SHALL, on mem_rvalid_i with the FIFO non-empty, pop the head and route the response to the tagged source:
- assert that source's rvalid_o and copy mem_rdata_i to its rdata_o in the same cycle;
- hold the other source's rvalid_o at 0.
REQ-023 SHALL, on mem_rvalid_i with the FIFO empty, drop the response and set err_o, which holds until reset.
REQ-024 SHALL handle a push and a pop in the same cycle with the occupancy unchanged, including when the FIFO is full, because the pop frees the slot.
REQ-025 SHALL drive rdata_o of a port to 0 whenever that port's rvalid_o=0.
REQ-026 SHALL accept at most one request per cycle with zero added latency (combinational pass-through).

Reset
REQ-027 SHALL, while rst_ni=0:
- empty the FIFO;
- clear the starvation counter, the grant lock and err_o;
- force all ready_o, rvalid_o and mem_valid_o to 0.
REQ-028 SHALL discard any read tags outstanding at reset, so that a later mem_rvalid_i sets err_o.

Configuration
REQ-029 SHALL, when MEM_ARB_STARVE_GUARD_EN is defined, implement REQ-019/020 as written.
REQ-030 SHALL, when MEM_ARB_STARVE_GUARD_EN is undefined, remove the counter so that data always wins, with StarveLimit unused.

Verification
REQ-031 SHALL cover the case where both request reads (inst 0x100, data 0x2000) with mem_ready_i=1: data is accepted first, inst the next cycle, and responses 0xAAAA then 0xBBBB route to data_rdata_o then inst_rdata_o.
REQ-032 SHALL cover the case where, with guard enabled and StarveLimit=4, data_valid_i and inst_valid_i are held high for 10 cycles: inst is granted in cycle 5 and cycle 10, data in all others.
REQ-033 SHALL cover the case where mem_ready_i=0 for 3 cycles while inst is granted, then data_valid_i rises: the grant and mem_addr_o stay at the inst address until acceptance.
REQ-034 SHALL cover the case where DepthLog2=2 and 4 reads are accepted with no response: the 5th read sees ready_o=0 and mem_valid_o=0; an rvalid plus a new read in the same cycle is accepted.
REQ-035 SHALL cover the case where a data write (wmask 0xF, addr 0x40, wdata 0x1234) is followed by mem_rvalid_i: err_o=1 and no rvalid_o is asserted.
REQ-036 SHALL cover the case where rst_ni is asserted low with 2 reads outstanding and then released: all outputs are 0, and a subsequent mem_rvalid_i sets err_o.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester channels (inst, data), the shared memory request
// channel and the in-order memory read response channel of mem_arbiter.
//   slave  : the arbiter's view (takes requests, drives memory)
//   master : the surrounding system's view (requesters plus memory model)
// Member names keep the arbiter-side direction affixes so the signal names
// match the arbiter's documented pin list.
// -----------------------------------------------------------------------------
interface mem_arbiter_if;

    // inst requester
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_wdata_i;
    logic [3:0]  inst_wmask_i;
    logic [31:0] inst_rdata_o;
    logic        inst_rvalid_o;

    // data requester
    logic        data_valid_i;
    logic        data_ready_o;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_wmask_i;
    logic [31:0] data_rdata_o;
    logic        data_rvalid_o;

    // shared memory port
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_rdata_i;
    logic        mem_rvalid_i;

    modport slave (
        input  inst_valid_i, inst_addr_i, inst_wdata_i, inst_wmask_i,
        output inst_ready_o, inst_rdata_o, inst_rvalid_o,
        input  data_valid_i, data_addr_i, data_wdata_i, data_wmask_i,
        output data_ready_o, data_rdata_o, data_rvalid_o,
        output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        input  mem_ready_i, mem_rdata_i, mem_rvalid_i
    );

    modport master (
        output inst_valid_i, inst_addr_i, inst_wdata_i, inst_wmask_i,
        input  inst_ready_o, inst_rdata_o, inst_rvalid_o,
        output data_valid_i, data_addr_i, data_wdata_i, data_wmask_i,
        input  data_ready_o, data_rdata_o, data_rvalid_o,
        input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
        output mem_ready_i, mem_rdata_i, mem_rvalid_i
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester (inst, data) arbiter in front of a single memory port.
// - Combinational pass-through: at most one request per cycle, no added latency.
// - Data has priority over inst; a stalled grant is locked until accepted.
// - Every accepted read pushes a 1-bit source tag into a small FIFO; in-order
//   read responses pop that FIFO and are steered back to the tagged source.
// - A response arriving with no outstanding read is dropped and raises the
//   sticky err_o flag.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//   defined   : after StarveLimit consecutive data grants while inst is waiting,
//               inst wins the next arbitration.
//   undefined : data always wins; StarveLimit is unused.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned DepthLog2   = 2,
    parameter int unsigned StarveLimit = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mem_arbiter_if.slave        bus,
    output logic                err_o
);

    localparam int unsigned         Depth     = 32'd1 << DepthLog2;
    localparam logic [DepthLog2:0]  CountFull = Depth[DepthLog2:0];
    localparam logic [DepthLog2:0]  CountZero = {(DepthLog2 + 1){1'b0}};
    localparam logic [DepthLog2:0]  CountOne  = (DepthLog2 + 1)'(1'b1);
    localparam logic [DepthLog2-1:0] PtrZero  = {DepthLog2{1'b0}};
    localparam logic [DepthLog2-1:0] PtrOne   = DepthLog2'(1'b1);
    localparam logic                SrcInst   = 1'b0;
    localparam logic                SrcData   = 1'b1;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic                   tag_mem_r [Depth];
    logic [DepthLog2-1:0]   wr_ptr_r;
    logic [DepthLog2-1:0]   rd_ptr_r;
    logic [DepthLog2:0]     count_r;
    logic                   lock_r;
    logic                   lock_sel_r;
    logic                   err_r;

    // ---------------------------------------------------------------------
    // Combinational signals
    // ---------------------------------------------------------------------
    logic                   starve_s;
    logic                   sel_data_s;
    logic                   win_valid_s;
    logic [31:0]            win_addr_s;
    logic [31:0]            win_wdata_s;
    logic [3:0]             win_wmask_s;
    logic                   win_is_read_s;
    logic                   fifo_empty_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   head_tag_s;
    logic                   track_full_s;
    logic                   read_blocked_s;
    logic                   mem_valid_s;
    logic                   grant_ready_s;
    logic                   accept_s;
    logic                   err_set_s;

    // ---------------------------------------------------------------------
    // Starvation guard
    // ---------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned     CntW      = $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] StarveMax = StarveLimit[CntW-1:0];
    localparam logic [CntW-1:0] CntZero   = {CntW{1'b0}};
    localparam logic [CntW-1:0] CntOne    = CntW'(1'b1);

    logic [CntW-1:0] starve_cnt_r;

    // Count consecutive accepted data grants while inst waits; any inst
    // acceptance or an idle inst requester restarts the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_r <= CntZero;
        end else if (!bus.inst_valid_i || (accept_s && (sel_data_s == SrcInst))) begin
            starve_cnt_r <= CntZero;
        end else if (accept_s && (sel_data_s == SrcData) && (starve_cnt_r != StarveMax)) begin
            starve_cnt_r <= starve_cnt_r + CntOne;
        end
    end

    assign starve_s = bus.inst_valid_i && (starve_cnt_r >= StarveMax);
`else
    // Without the guard data priority is absolute.
    assign starve_s = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Tracking FIFO status
    // ---------------------------------------------------------------------
    assign fifo_empty_s = (count_r == CountZero);
    assign head_tag_s   = tag_mem_r[rd_ptr_r];
    assign pop_s        = rst_ni && bus.mem_rvalid_i && !fifo_empty_s;
    assign err_set_s    = bus.mem_rvalid_i && fifo_empty_s;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a read.
    assign track_full_s = (count_r == CountFull) && !pop_s;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    // Pick the winner: a locked (stalled) grant holds, otherwise data beats
    // inst unless the starvation guard hands the slot to inst.
    always_comb begin
        sel_data_s = SrcInst;
        if (lock_r) begin
            sel_data_s = lock_sel_r;
        end else if (bus.data_valid_i && !starve_s) begin
            sel_data_s = SrcData;
        end else begin
            sel_data_s = SrcInst;
        end
    end

    // Multiplex the winning requester's request onto internal signals.
    always_comb begin
        win_valid_s = bus.inst_valid_i;
        win_addr_s  = bus.inst_addr_i;
        win_wdata_s = bus.inst_wdata_i;
        win_wmask_s = bus.inst_wmask_i;
        if (sel_data_s == SrcData) begin
            win_valid_s = bus.data_valid_i;
            win_addr_s  = bus.data_addr_i;
            win_wdata_s = bus.data_wdata_i;
            win_wmask_s = bus.data_wmask_i;
        end else begin
            win_valid_s = bus.inst_valid_i;
            win_addr_s  = bus.inst_addr_i;
            win_wdata_s = bus.inst_wdata_i;
            win_wmask_s = bus.inst_wmask_i;
        end
    end

    // Reads need a tracking slot; writes never produce a response and pass.
    assign win_is_read_s  = (win_wmask_s == 4'h0);
    assign read_blocked_s = win_is_read_s && track_full_s;
    assign mem_valid_s    = rst_ni && win_valid_s && !read_blocked_s;
    assign grant_ready_s  = rst_ni && bus.mem_ready_i && !read_blocked_s;
    assign accept_s       = mem_valid_s && bus.mem_ready_i;
    assign push_s         = accept_s && win_is_read_s;

    // Drive the memory request and the requester handshakes; the loser
    // always sees ready low.
    always_comb begin
        bus.mem_valid_o  = mem_valid_s;
        bus.mem_addr_o   = win_addr_s;
        bus.mem_wdata_o  = win_wdata_s;
        bus.mem_wmask_o  = 4'h0;
        bus.inst_ready_o = 1'b0;
        bus.data_ready_o = 1'b0;
        if (win_valid_s) begin
            bus.mem_wmask_o = win_wmask_s;
        end else begin
            bus.mem_wmask_o = 4'h0;
        end
        if (sel_data_s == SrcData) begin
            bus.data_ready_o = grant_ready_s;
        end else begin
            bus.inst_ready_o = grant_ready_s;
        end
    end

    // Route a popped response to its tagged source; rdata is zero whenever
    // the matching rvalid is low.
    always_comb begin
        bus.inst_rvalid_o = 1'b0;
        bus.data_rvalid_o = 1'b0;
        bus.inst_rdata_o  = 32'h0000_0000;
        bus.data_rdata_o  = 32'h0000_0000;
        if (pop_s && (head_tag_s == SrcData)) begin
            bus.data_rvalid_o = 1'b1;
            bus.data_rdata_o  = bus.mem_rdata_i;
        end else if (pop_s && (head_tag_s == SrcInst)) begin
            bus.inst_rvalid_o = 1'b1;
            bus.inst_rdata_o  = bus.mem_rdata_i;
        end else begin
            bus.inst_rvalid_o = 1'b0;
            bus.data_rvalid_o = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------
    // Hold the grant while the memory stalls a presented request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_r     <= 1'b0;
            lock_sel_r <= SrcInst;
        end else if (mem_valid_s && !bus.mem_ready_i) begin
            lock_r     <= 1'b1;
            lock_sel_r <= sel_data_s;
        end else begin
            lock_r     <= 1'b0;
            lock_sel_r <= SrcInst;
        end
    end

    // Tag FIFO storage and write pointer; reset discards outstanding tags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                tag_mem_r[i] <= SrcInst;
            end
            wr_ptr_r <= PtrZero;
        end else if (push_s) begin
            tag_mem_r[wr_ptr_r] <= sel_data_s;
            wr_ptr_r            <= wr_ptr_r + PtrOne;
        end
    end

    // Tag FIFO read pointer, advanced on every routed response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r <= PtrZero;
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PtrOne;
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= CountZero;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CountOne;
                2'b01:   count_r <= count_r - CountOne;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error on a response that has no outstanding read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed stimulus with a scoreboard: stimulus pushes the expected memory
// requests and read responses into queues; a negedge monitor pops and compares
// whenever the arbiter presents an accepted request or a read response.
// Works with or without MEM_ARB_STARVE_GUARD_EN defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct {
        logic        src;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    logic clk_i;
    logic rst_ni;
    logic err_o;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .DepthLog2   (2),
        .StarveLimit (4)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus),
        .err_o  (err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    req_t        exp_mem_q [$];
    logic [31:0] exp_inst_q [$];
    logic [31:0] exp_data_q [$];

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_inst(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.inst_valid_i = v;
        bus.inst_addr_i  = a;
        bus.inst_wdata_i = d;
        bus.inst_wmask_i = m;
    endtask

    task automatic set_data(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.data_valid_i = v;
        bus.data_addr_i  = a;
        bus.data_wdata_i = d;
        bus.data_wmask_i = m;
    endtask

    task automatic exp_req(input logic s, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        req_t r;
        r.src = s; r.addr = a; r.wdata = d; r.wmask = m;
        exp_mem_q.push_back(r);
    endtask

    // Pulse one memory read response for a cycle.
    task automatic respond(input logic [31:0] d);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = d;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
    endtask

    // Monitor: compare every accepted request and every routed response.
    req_t mon_r;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (bus.mem_valid_o && bus.mem_ready_i) begin
                if (exp_mem_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL mem_accept: unexpected accept addr 0x%0h, none required", bus.mem_addr_o);
                end else begin
                    mon_r = exp_mem_q.pop_front();
                    chk("mem_addr",  bus.mem_addr_o,  mon_r.addr);
                    chk("mem_wdata", bus.mem_wdata_o, mon_r.wdata);
                    chk("mem_wmask", {28'h0, bus.mem_wmask_o}, {28'h0, mon_r.wmask});
                    chk("grant_inst_ready", {31'h0, bus.inst_ready_o}, {31'h0, ~mon_r.src});
                    chk("grant_data_ready", {31'h0, bus.data_ready_o}, {31'h0, mon_r.src});
                end
            end
            if (bus.inst_rvalid_o) begin
                if (exp_inst_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL inst_rvalid: unexpected response 0x%0h, none required", bus.inst_rdata_o);
                end else begin
                    chk("inst_rdata", bus.inst_rdata_o, exp_inst_q.pop_front());
                end
            end else if (bus.inst_rdata_o !== 32'h0) begin
                n_checks++; n_errors++;
                $display("FAIL inst_rdata_idle: got 0x%0h required 0x0", bus.inst_rdata_o);
            end
            if (bus.data_rvalid_o) begin
                if (exp_data_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL data_rvalid: unexpected response 0x%0h, none required", bus.data_rdata_o);
                end else begin
                    chk("data_rdata", bus.data_rdata_o, exp_data_q.pop_front());
                end
            end else if (bus.data_rdata_o !== 32'h0) begin
                n_checks++; n_errors++;
                $display("FAIL data_rdata_idle: got 0x%0h required 0x0", bus.data_rdata_o);
            end
        end
    end

    initial begin
        logic guard;
`ifdef MEM_ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        rst_ni = 1'b0;
        set_inst(1'b0, 32'h0, 32'h0, 4'h0);
        set_data(1'b0, 32'h0, 32'h0, 4'h0);
        bus.mem_ready_i  = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        bus.mem_rvalid_i = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst_err",        {31'h0, err_o},            32'h0);
        chk("rst_mem_valid",  {31'h0, bus.mem_valid_o},  32'h0);
        chk("rst_mem_wmask",  {28'h0, bus.mem_wmask_o},  32'h0);
        chk("rst_inst_ready", {31'h0, bus.inst_ready_o}, 32'h0);
        chk("rst_data_ready", {31'h0, bus.data_ready_o}, 32'h0);
        rst_ni = 1'b1;
        tick();

        // Both read together: data first, then inst; responses route in order.
        bus.mem_ready_i = 1'b1;
        set_inst(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        set_data(1'b1, 32'h0000_2000, 32'h0, 4'h0);
        exp_req(1'b1, 32'h0000_2000, 32'h0, 4'h0);
        exp_req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        tick();
        set_data(1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        set_inst(1'b0, 32'h0, 32'h0, 4'h0);
        exp_data_q.push_back(32'h0000_AAAA);
        exp_inst_q.push_back(32'h0000_BBBB);
        respond(32'h0000_AAAA);
        respond(32'h0000_BBBB);

        // Both held high for 10 cycles with writes (no FIFO pressure).
        set_inst(1'b1, 32'h0000_0100, 32'h1111_0000, 4'hF);
        set_data(1'b1, 32'h0000_2000, 32'h2222_0000, 4'h3);
        for (int c = 1; c <= 10; c++) begin
            if (guard && (c % 5 == 0)) begin
                exp_req(1'b0, 32'h0000_0100, 32'h1111_0000, 4'hF);
            end else begin
                exp_req(1'b1, 32'h0000_2000, 32'h2222_0000, 4'h3);
            end
            tick();
        end
        set_inst(1'b0, 32'h0, 32'h0, 4'h0);
        set_data(1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Stalled inst grant stays locked when data arrives.
        bus.mem_ready_i = 1'b0;
        set_inst(1'b1, 32'h0000_0100, 32'h0, 4'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall_mem_addr",  bus.mem_addr_o, 32'h0000_0100);
            chk("stall_mem_valid", {31'h0, bus.mem_valid_o}, 32'h1);
        end
        set_data(1'b1, 32'h0000_2000, 32'h0, 4'h0);
        #1;
        chk("lock_mem_addr",   bus.mem_addr_o, 32'h0000_0100);
        chk("lock_data_ready", {31'h0, bus.data_ready_o}, 32'h0);
        tick();
        chk("lock_mem_addr2",  bus.mem_addr_o, 32'h0000_0100);
        bus.mem_ready_i = 1'b1;
        #1;
        chk("lock_inst_ready", {31'h0, bus.inst_ready_o}, 32'h1);
        exp_req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        tick();
        set_inst(1'b0, 32'h0, 32'h0, 4'h0);
        exp_req(1'b1, 32'h0000_2000, 32'h0, 4'h0);
        tick();
        set_data(1'b0, 32'h0, 32'h0, 4'h0);
        exp_inst_q.push_back(32'h0000_1111);
        exp_data_q.push_back(32'h0000_2222);
        respond(32'h0000_1111);
        respond(32'h0000_2222);

        // Fill the tracking FIFO with 4 data reads.
        for (int i = 0; i < 4; i++) begin
            set_data(1'b1, 32'h0000_3000 + 32'(i * 4), 32'h0, 4'h0);
            exp_req(1'b1, 32'h0000_3000 + 32'(i * 4), 32'h0, 4'h0);
            tick();
        end
        set_data(1'b1, 32'h0000_3010, 32'h0, 4'h0);
        #1;
        chk("full_data_ready", {31'h0, bus.data_ready_o}, 32'h0);
        chk("full_mem_valid",  {31'h0, bus.mem_valid_o},  32'h0);
        tick();
        chk("full_mem_valid2", {31'h0, bus.mem_valid_o},  32'h0);
        // Response and new read in the same cycle: the pop frees the slot.
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_00C0;
        exp_data_q.push_back(32'h0000_00C0);
        #1;
        chk("pushpop_data_ready", {31'h0, bus.data_ready_o}, 32'h1);
        chk("pushpop_mem_valid",  {31'h0, bus.mem_valid_o},  32'h1);
        exp_req(1'b1, 32'h0000_3010, 32'h0, 4'h0);
        tick();
        bus.mem_rvalid_i = 1'b0;
        set_data(1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("still_full_after_pushpop", {31'h0, dut.track_full_s}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            exp_data_q.push_back(32'h0000_00C0 + 32'(i));
            respond(32'h0000_00C0 + 32'(i));
        end
        chk("err_before_write", {31'h0, err_o}, 32'h0);

        // A write produces no response: the next rvalid is an error.
        set_data(1'b1, 32'h0000_0040, 32'h0000_1234, 4'hF);
        exp_req(1'b1, 32'h0000_0040, 32'h0000_1234, 4'hF);
        tick();
        set_data(1'b0, 32'h0, 32'h0, 4'h0);
        respond(32'h0000_DEAD);
        chk("write_rsp_err", {31'h0, err_o}, 32'h1);
        tick();
        chk("err_sticky", {31'h0, err_o}, 32'h1);

        // Reset with 2 reads outstanding discards their tags.
        set_data(1'b1, 32'h0000_0600, 32'h0, 4'h0);
        exp_req(1'b1, 32'h0000_0600, 32'h0, 4'h0);
        tick();
        set_data(1'b1, 32'h0000_0604, 32'h0, 4'h0);
        exp_req(1'b1, 32'h0000_0604, 32'h0, 4'h0);
        tick();
        rst_ni = 1'b0;
        set_inst(1'b1, 32'h0000_0700, 32'h0, 4'h0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_0077;
        #1;
        chk("inrst_mem_valid",   {31'h0, bus.mem_valid_o},   32'h0);
        chk("inrst_inst_ready",  {31'h0, bus.inst_ready_o},  32'h0);
        chk("inrst_data_ready",  {31'h0, bus.data_ready_o},  32'h0);
        chk("inrst_data_rvalid", {31'h0, bus.data_rvalid_o}, 32'h0);
        chk("inrst_inst_rvalid", {31'h0, bus.inst_rvalid_o}, 32'h0);
        chk("inrst_err",         {31'h0, err_o},             32'h0);
        tick();
        set_inst(1'b0, 32'h0, 32'h0, 4'h0);
        set_data(1'b0, 32'h0, 32'h0, 4'h0);
        bus.mem_ready_i  = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_mem_valid", {31'h0, bus.mem_valid_o}, 32'h0);
        chk("post_rst_mem_addr",  bus.mem_addr_o,  32'h0);
        chk("post_rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("post_rst_mem_wmask", {28'h0, bus.mem_wmask_o}, 32'h0);
        chk("post_rst_ready",     {30'h0, bus.inst_ready_o, bus.data_ready_o}, 32'h0);
        chk("post_rst_rvalid",    {30'h0, bus.inst_rvalid_o, bus.data_rvalid_o}, 32'h0);
        chk("post_rst_rdata",     bus.inst_rdata_o | bus.data_rdata_o, 32'h0);
        chk("post_rst_err",       {31'h0, err_o}, 32'h0);
        respond(32'h0000_0055);
        chk("post_rst_rsp_err",   {31'h0, err_o}, 32'h1);

        tick();
        chk("exp_mem_drained",  32'(exp_mem_q.size()),  32'h0);
        chk("exp_inst_drained", 32'(exp_inst_q.size()), 32'h0);
        chk("exp_data_drained", 32'(exp_data_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mem_arbiter
